// File: rtl/vga_dither_out_if.sv
// vga_dither_out_if
//  Bundles the video stream from the generator with the pin-side outputs of the
//  VGA output stage. The generator side uses the master modport and the output
//  stage uses the slave modport.
//
//  Handshake: there is none. This is a free-running pixel stream. Every clock
//  carries one sample, and VGA_DE_IN marks the active pixels. The outputs follow
//  their inputs with a fixed 2-clock latency and never stall.
//
//  Signals
//   DITHER_EN     gen -> stage  1 = apply the dither mode, 0 = truncate
//   VGA_HSYNC_IN  gen -> stage  horizontal sync
//   VGA_VSYNC_IN  gen -> stage  vertical sync
//   VGA_DE_IN     gen -> stage  active pixel flag
//   RED/GREEN/BLUE_IN gen -> stage  IN_W-bit colour
//   VGA_HSYNC/VGA_VSYNC stage -> pins  registered syncs
//   VGA_RED/GREEN/BLUE  stage -> pins  OUT_W-bit dithered colour
interface vga_dither_out_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) ();
    logic             DITHER_EN;
    logic             VGA_HSYNC_IN;
    logic             VGA_VSYNC_IN;
    logic             VGA_DE_IN;
    logic [IN_W-1:0]  RED_IN;
    logic [IN_W-1:0]  GREEN_IN;
    logic [IN_W-1:0]  BLUE_IN;
    logic             VGA_HSYNC;
    logic             VGA_VSYNC;
    logic [OUT_W-1:0] VGA_RED;
    logic [OUT_W-1:0] VGA_GREEN;
    logic [OUT_W-1:0] VGA_BLUE;

    modport master (
        output DITHER_EN, VGA_HSYNC_IN, VGA_VSYNC_IN, VGA_DE_IN,
        output RED_IN, GREEN_IN, BLUE_IN,
        input  VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
    );

    modport slave (
        input  DITHER_EN, VGA_HSYNC_IN, VGA_VSYNC_IN, VGA_DE_IN,
        input  RED_IN, GREEN_IN, BLUE_IN,
        output VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
    );
endinterface

// File: rtl/vga_dither_out.sv
// vga_dither_out
//  This is the VGA output stage. It reduces IN_W-bit colour channels to OUT_W-bit
//  DAC pins using ordered (Bayer) dithering, and it blanks colour outside the
//  active area. Syncs and colour share the same 2-clock latency.
//
//  Ports
//   CLK_25MHZ  in  pixel clock
//   RESET_N    in  asynchronous, active-low reset
//   vga        slave side of vga_dither_out_if (stream in, pins out)
//
//  Parameters: IN_W, OUT_W (OUT_W <= IN_W), DITHER (0 none, 1 2x2, 2 4x4),
//  and HSYNC_POL / VSYNC_POL (the active level of each sync).
module vga_dither_out #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 4,
    parameter int DITHER    = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic           CLK_25MHZ,
    input  logic           RESET_N,
    vga_dither_out_if.slave vga
);

    localparam int D    = IN_W - OUT_W;
    localparam int LOGN = (DITHER == 2) ? 4 : 2;
    // The threshold is entry * 2^D / N. It is done as one shift, whose
    // direction depends on whether D reaches log2(N).
    localparam int SHL  = (D >= LOGN) ? (D - LOGN) : 0;
    localparam int SHR  = (D >= LOGN) ? 0 : (LOGN - D);

    generate
        if (OUT_W > IN_W) begin : g_bad_width
            $error("vga_dither_out: OUT_W must not exceed IN_W");
        end
    endgenerate

    function automatic logic [3:0] bayer4(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] e;
        case ({y, x})
            4'd0:  e = 4'd0;   4'd1:  e = 4'd8;   4'd2:  e = 4'd2;   4'd3:  e = 4'd10;
            4'd4:  e = 4'd12;  4'd5:  e = 4'd4;   4'd6:  e = 4'd14;  4'd7:  e = 4'd6;
            4'd8:  e = 4'd3;   4'd9:  e = 4'd11;  4'd10: e = 4'd1;   4'd11: e = 4'd9;
            4'd12: e = 4'd15;  4'd13: e = 4'd7;   4'd14: e = 4'd13;  default: e = 4'd5;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] bayer2(input logic y0, input logic x0);
        logic [3:0] e;
        case ({y0, x0})
            2'b00:   e = 4'd0;
            2'b01:   e = 4'd2;
            2'b10:   e = 4'd3;
            default: e = 4'd1;
        endcase
        return e;
    endfunction

    // When the carry bit is set, the result must pin to full scale rather
    // than wrap back to a dark value.
    function automatic logic [OUT_W-1:0] sat(input logic [IN_W:0] s);
        if (s[IN_W]) return '1;
        return s[IN_W-1:D];
    endfunction

    logic [1:0]       x_ph_q, x_ph_d;
    logic [1:0]       y_ph_q, y_ph_d;
    logic             de_s1_q, hs_s1_q, vs_s1_q;
    logic [IN_W:0]    r_s1_q, g_s1_q, b_s1_q;
    logic [IN_W:0]    r_s1_d, g_s1_d, b_s1_d;
    logic             hs_s2_q, vs_s2_q;
    logic [OUT_W-1:0] r_s2_q, g_s2_q, b_s2_q;
    logic [OUT_W-1:0] r_s2_d, g_s2_d, b_s2_d;
    logic [3:0]       entry;
    logic [IN_W:0]    thr;
    logic             vs_active;

    always_comb begin
        vs_active = (vga.VGA_VSYNC_IN == VSYNC_POL);

        // x_ph counts pixels within the active run, so every line starts at 0.
        x_ph_d = vga.VGA_DE_IN ? x_ph_q + 2'd1 : 2'd0;

        // y_ph advances at the end of each active run. Vsync holds it at 0,
        // which keeps the pattern frame-aligned.
        y_ph_d = y_ph_q;
        if (vs_active)
            y_ph_d = 2'd0;
        else if (de_s1_q && !vga.VGA_DE_IN)
            y_ph_d = y_ph_q + 2'd1;

        entry = 4'd0;
        if (DITHER == 2)
            entry = bayer4(y_ph_q, x_ph_q);
        else if (DITHER == 1)
            entry = bayer2(y_ph_q[0], x_ph_q[0]);

        thr = '0;
        if ((DITHER != 0) && vga.DITHER_EN && (D != 0))
            thr = ({{(IN_W-3){1'b0}}, entry} << SHL) >> SHR;

        r_s1_d = {1'b0, vga.RED_IN}   + thr;
        g_s1_d = {1'b0, vga.GREEN_IN} + thr;
        b_s1_d = {1'b0, vga.BLUE_IN}  + thr;

        r_s2_d = de_s1_q ? sat(r_s1_q) : '0;
        g_s2_d = de_s1_q ? sat(g_s1_q) : '0;
        b_s2_d = de_s1_q ? sat(b_s1_q) : '0;
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            x_ph_q  <= 2'd0;
            y_ph_q  <= 2'd0;
            de_s1_q <= 1'b0;
            hs_s1_q <= ~HSYNC_POL;
            vs_s1_q <= ~VSYNC_POL;
            r_s1_q  <= '0;
            g_s1_q  <= '0;
            b_s1_q  <= '0;
            hs_s2_q <= ~HSYNC_POL;
            vs_s2_q <= ~VSYNC_POL;
            r_s2_q  <= '0;
            g_s2_q  <= '0;
            b_s2_q  <= '0;
        end else begin
            x_ph_q  <= x_ph_d;
            y_ph_q  <= y_ph_d;
            de_s1_q <= vga.VGA_DE_IN;
            hs_s1_q <= vga.VGA_HSYNC_IN;
            vs_s1_q <= vga.VGA_VSYNC_IN;
            r_s1_q  <= r_s1_d;
            g_s1_q  <= g_s1_d;
            b_s1_q  <= b_s1_d;
            hs_s2_q <= hs_s1_q;
            vs_s2_q <= vs_s1_q;
            r_s2_q  <= r_s2_d;
            g_s2_q  <= g_s2_d;
            b_s2_q  <= b_s2_d;
        end
    end

    assign vga.VGA_HSYNC = hs_s2_q;
    assign vga.VGA_VSYNC = vs_s2_q;
    assign vga.VGA_RED   = r_s2_q;
    assign vga.VGA_GREEN = g_s2_q;
    assign vga.VGA_BLUE  = b_s2_q;

endmodule
